// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-cache, D-cache and main-memory buses that meet
// at the memory arbiter. The "slave" modport is the arbiter's view. The
// "master" modport is the view of the surrounding cache controllers and memory.
//
// Handshake semantics (shared by both requester sides):
//   - A requester raises read and/or write together with addr/wdata. It holds
//     them stable until its ready pulse.
//   - ready is a one-cycle pulse that completes the transaction. rdata is only
//     meaningful in that cycle.
//   - The requester must drop its request in the cycle after ready. A request
//     still high then is taken as a new transaction.
//   - On the memory side, mem_read/mem_write stay high until mem_ready pulses.
//     mem_rdata is valid in the same cycle as mem_ready.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    // I-cache side
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic              i_ready;
    logic [DATA_W-1:0] i_rdata;

    // D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    // Main-memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_ready, i_rdata,
        input  d_read, d_write, d_addr, d_wdata,
        output d_ready, d_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    // Cache controllers and memory view
    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_ready, i_rdata,
        output d_read, d_write, d_addr, d_wdata,
        input  d_ready, d_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache and D-cache.
// Each memory transaction is granted to one requester. Ties in IDLE alternate
// round-robin based on the side served last. The granted requester's command
// and data pass straight through to memory. The memory response is steered
// back as a one-cycle ready pulse.
// Two saturating counters record how many cycles each side spent requesting
// without holding the grant.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] i_wait_cnt,
    output logic [CNT_W-1:0] d_wait_cnt,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    // Which side was served most recently; the other side wins the next tie.
    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } side_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Control registers
    state_t            r_state;
    side_t             r_last;
    logic [CNT_W-1:0]  r_i_wait_cnt;
    logic [CNT_W-1:0]  r_d_wait_cnt;

    // Combinational next-state and outputs
    state_t            w_next_state;
    side_t             w_next_last;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_mem_read;
    logic              w_mem_write;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_i_ready;
    logic              w_d_ready;
    logic              w_i_waiting;
    logic              w_d_waiting;

    // A side is active whenever it asks for either a read or a write.
    assign w_req_i = bus.i_read | bus.i_write;
    assign w_req_d = bus.d_read | bus.d_write;

    // A side is waiting when it requests but does not own the memory port.
    // This includes the IDLE arbitration cycle.
    assign w_i_waiting = w_req_i && (r_state != ST_GNT_I);
    assign w_d_waiting = w_req_d && (r_state != ST_GNT_D);

    // State and last-grant registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= LAST_I;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
        end
    end

    // Arbitration, command pass-through and ready steering.
    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_i_ready    = 1'b0;
        w_d_ready    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // mem_ready seen here belongs to no one and is dropped.
                if (w_req_i && w_req_d) begin
                    w_next_state = (r_last == LAST_I) ? ST_GNT_D : ST_GNT_I;
                end else if (w_req_d) begin
                    w_next_state = ST_GNT_D;
                end else if (w_req_i) begin
                    w_next_state = ST_GNT_I;
                end
            end

            ST_GNT_I: begin
                // Read and write are forwarded as-is, even both at once.
                w_mem_read  = bus.i_read;
                w_mem_write = bus.i_write;
                w_mem_addr  = bus.i_addr;
                w_mem_wdata = bus.i_wdata;
                if (bus.mem_ready) begin
                    w_i_ready    = 1'b1;
                    w_next_state = ST_IDLE;
                    w_next_last  = LAST_I;
                end
            end

            ST_GNT_D: begin
                w_mem_read  = bus.d_read;
                w_mem_write = bus.d_write;
                w_mem_addr  = bus.d_addr;
                w_mem_wdata = bus.d_wdata;
                if (bus.mem_ready) begin
                    w_d_ready    = 1'b1;
                    w_next_state = ST_IDLE;
                    w_next_last  = LAST_D;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // I-side wait counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_wait_cnt <= '0;
        end else if (w_i_waiting && (r_i_wait_cnt != CNT_MAX)) begin
            r_i_wait_cnt <= r_i_wait_cnt + CNT_ONE;
        end
    end

    // D-side wait counter, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_wait_cnt <= '0;
        end else if (w_d_waiting && (r_d_wait_cnt != CNT_MAX)) begin
            r_d_wait_cnt <= r_d_wait_cnt + CNT_ONE;
        end
    end

    // Memory command and data go out directly from the granted side.
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    // Read data is broadcast to both sides; only the ready pulse qualifies it.
    assign bus.i_ready   = w_i_ready;
    assign bus.d_ready   = w_d_ready;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    assign i_wait_cnt    = r_i_wait_cnt;
    assign d_wait_cnt    = r_d_wait_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the I-cache and D-cache miss/write-back interfaces, so that both cache controllers can sit behind one slow memory. The block grants one requester per transaction, passes the granted requester's command and data through to memory, and routes the memory response back to that requester. Two saturating wait-cycle counters provide contention statistics for the pipeline performance study.

## Interface

Parameters:
- ADDR_W, 28, block address width (one 128-bit line per address)
- DATA_W, 128, line width
- CNT_W, 32, width of the wait-cycle counters

Ports:
- Clocking: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_read  in  1  I-cache memory read request, held until i_ready
- i_write  in  1  I-cache memory write request (tied 0 in normal use, still arbitrated)
- i_addr  in  ADDR_W  I-cache block address
- i_wdata  in  DATA_W  I-cache write line
- i_ready  out  1  I-side transaction complete, 1-cycle pulse
- i_rdata  out  DATA_W  I-side read line, valid when i_ready=1
- d_read  in  1  D-cache memory read request, held until d_ready
- d_write  in  1  D-cache write-back request, held until d_ready
- d_addr  in  ADDR_W  D-cache block address
- d_wdata  in  DATA_W  D-cache write line
- d_ready  out  1  D-side transaction complete, 1-cycle pulse
- d_rdata  out  DATA_W  D-side read line, valid when d_ready=1
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_addr  out  ADDR_W  memory block address
- mem_wdata  out  DATA_W  memory write line
- mem_ready  in  1  memory completion pulse; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read line
- i_wait_cnt  out  CNT_W  cycles the I-side was requesting but not granted
- d_wait_cnt  out  CNT_W  cycles the D-side was requesting but not granted

## Operation

- A requester is active when it asserts either read or write: `req_i = i_read|i_write`, `req_d = d_read|d_write`.
- State machine with three states: IDLE, GNT_I, GNT_D. The state register and the last-grant flag `last` (values I or D) are the only control registers.
- IDLE:
  - req_d only → GNT_D.
  - req_i only → GNT_I.
  - Both active → grant the side not in `last` (round-robin). `last` resets to I, so D wins the first tie.
  - Neither active → stay in IDLE.
- GNT_x:
  - mem_read, mem_write, mem_addr and mem_wdata are driven combinationally from requester x.
  - On mem_ready=1: x_ready=1 and x_rdata=mem_rdata in that cycle; next state is IDLE and `last`←x.
  - Requests from the other side are ignored until the grant returns to IDLE.
- In IDLE, mem_read=mem_write=0. mem_addr and mem_wdata are 0 in IDLE.
- i_rdata and d_rdata always carry mem_rdata. Each is qualified only by its own ready.
- A requester asserting both read and write is forwarded unchanged. Memory defines the result; the arbiter does not check for it.
- Wait counters:
  - i_wait_cnt increments in every cycle where req_i=1 and state≠GNT_I.
  - d_wait_cnt increments in every cycle where req_d=1 and state≠GNT_D.
  - This includes the IDLE arbitration cycle.
  - Both counters saturate at 2^CNT_W−1 and do not wrap.
- Reset (any time, including mid-transaction):
  - state=IDLE, last=I, counters=0, all outputs 0.
  - An in-flight memory transaction is abandoned. Memory must be reset together with the arbiter.

## Timing

- Request sampled in IDLE at cycle n → grant state at n+1 → memory command visible at n+1. Arbitration latency is 1 cycle.
- mem_ready at cycle k → x_ready at k, combinational path from mem_ready to x_ready.
- State returns to IDLE at k+1, with mem_read and mem_write low at k+1. A new grant therefore appears at k+2 at the earliest. There is at least one idle memory cycle between transactions.
- The served requester must drop its request by k+1. A request still high at k+1 is treated as a new transaction.
- mem_ready while in IDLE is ignored: no ready pulse is issued and the state does not change.
- Requests must remain stable while granted. Address or data changes mid-grant pass straight through to memory.

## Test plan

- D read alone: d_read=1, d_addr=0x0000123. Expect mem_read=1 with mem_addr=0x0000123 one cycle later. Memory returns mem_ready after 4 cycles with mem_rdata=0xDEADBEEF…. Expect d_ready for 1 cycle with d_rdata equal to that line, i_ready=0, and d_wait_cnt=1.
- Simultaneous requests after reset: i_read and d_write asserted in the same cycle. Expect D granted first (mem_write=1, mem_wdata=d_wdata). After d_ready, I is granted at k+2. i_wait_cnt covers the whole D transaction plus the arbitration cycles.
- Round-robin: both sides hold requests continuously across 4 transactions. Expect grant order D, I, D, I with one idle memory cycle between transactions.
- Spurious mem_ready in IDLE with no requests: expect i_ready=d_ready=0, state stays IDLE, and counters unchanged.
- Reset mid-grant: assert rst while in GNT_I with memory busy. Expect all outputs 0 immediately (asynchronous), and after release the next tie goes to D.
- Counter saturation with CNT_W=4: hold i_read for 20 cycles while D is granted. Expect i_wait_cnt to stop at 15.
